// File: rtl/rs232_frame_decoder_pkg.sv
// Shared definitions for the RS232 command frame decoder.
// Holds the decoder state encoding, the default frame start marker, the
// frame length and the frame checksum helper used by the decoder.
package rs232_frame_decoder_pkg;

  // Default start-of-frame marker.
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Bytes per frame: SYNC, CMD, DH, DL, CHK.
  localparam int FRAME_LEN = 5;

  // Decoder states. Each state names the byte the decoder expects next.
  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_CMD  = 3'd1,
    ST_DH   = 3'd2,
    ST_DL   = 3'd3,
    ST_CHK  = 3'd4
  } frame_state_t;

  // Frame checksum: XOR of the command byte and both data bytes.
  function automatic logic [7:0] calc_chk(
    input logic [7:0] cmd_byte,
    input logic [7:0] dh_byte,
    input logic [7:0] dl_byte
  );
    return cmd_byte ^ dh_byte ^ dl_byte;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Purpose: inter-byte gap timer; counts idle cycles while a frame is open.
// Latency: expire is combinational from the count, asserted once TIMEOUT-1 is reached.
// Backpressure: none; clear and run are sampled every cycle.
//
// Ports:
//   clock, resetn : clock and asynchronous active-low reset
//   clear         : restart the count from zero (a byte arrived)
//   run           : count only while asserted (frame in progress)
//   expire        : the gap has reached TIMEOUT-1 cycles
module frame_timer #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic expire
);

  // A one-bit counter keeps the degenerate TIMEOUT=1 case legal.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  assign expire = run && (count == LAST);

  // The count is held at zero outside a frame so that the first gap after
  // the sync byte is measured from the sync byte itself. After an expiry the
  // owner drops run, so wrapping to zero here is only for tidiness.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear || !run || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rs232_frame_decoder.sv
// Purpose: decodes SYNC,CMD,DH,DL,CHK byte frames into register commands.
// Latency: cmd_enable pulses one cycle after the CHK byte strobe.
// Backpressure: never refuses a byte; cmd_afull is only reflected back on iafull.
//
// Ports:
//   clock, resetn           : clock and asynchronous active-low reset
//   idata, ienable          : byte stream from the serial receiver (push strobe)
//   iafull                  : cmd_afull delayed one cycle, towards the receiver
//   cmd_write/addr/data     : decoded command, held until the next good frame
//   cmd_enable              : one-cycle push strobe for the decoded command
//   cmd_afull               : almost-full from the command consumer
//   err_count               : saturating count of checksum and gap errors
module rs232_frame_decoder
  import rs232_frame_decoder_pkg::*;
#(
  parameter int         TIMEOUT   = 1000000,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [7:0]  idata,
  input  logic        ienable,
  output logic        iafull,
  output logic        cmd_write,
  output logic [6:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        cmd_enable,
  input  logic        cmd_afull,
  output logic [7:0]  err_count
);

  frame_state_t state;
  frame_state_t state_nxt;

  // Frame bytes captured so far.
  logic [7:0] cmd_byte;
  logic [7:0] dh_byte;
  logic [7:0] dl_byte;

  logic frame_ok;
  logic frame_bad;
  logic gap_error;
  logic timer_expire;
  logic timer_run;

  // ---------------------------------------------------------------------
  // Gap timer: restarted by every byte, counting only inside a frame.
  // ---------------------------------------------------------------------
  assign timer_run = (state != ST_HUNT);

  frame_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_frame_timer (
    .clock (clock),
    .resetn(resetn),
    .clear (ienable),
    .run   (timer_run),
    .expire(timer_expire)
  );

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // A byte always takes priority over a coincident gap expiry, so the
  // timeout branch is only reached on cycles without ienable.
  always_comb begin
    state_nxt = state;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    gap_error = 1'b0;

    if (ienable) begin
      case (state)
        ST_HUNT: begin
          // Anything other than the marker is line noise between frames.
          if (idata == SYNC_BYTE) begin
            state_nxt = ST_CMD;
          end
        end
        // Inside a frame the marker value is ordinary payload.
        ST_CMD: state_nxt = ST_DH;
        ST_DH:  state_nxt = ST_DL;
        ST_DL:  state_nxt = ST_CHK;
        ST_CHK: begin
          if (idata == calc_chk(cmd_byte, dh_byte, dl_byte)) begin
            frame_ok = 1'b1;
          end else begin
            frame_bad = 1'b1;
          end
          state_nxt = ST_HUNT;
        end
        default: state_nxt = ST_HUNT;
      endcase
    end else if (timer_expire) begin
      gap_error = 1'b1;
      state_nxt = ST_HUNT;
    end
  end

  // ---------------------------------------------------------------------
  // Byte capture
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cmd_byte <= '0;
      dh_byte  <= '0;
      dl_byte  <= '0;
    end else if (ienable) begin
      if (state == ST_CMD) begin
        cmd_byte <= idata;
      end
      if (state == ST_DH) begin
        dh_byte <= idata;
      end
      if (state == ST_DL) begin
        dl_byte <= idata;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Command outputs: updated only by a frame whose checksum matches, so a
  // bad or truncated frame leaves the last good command visible.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cmd_enable <= 1'b0;
      cmd_write  <= 1'b0;
      cmd_addr   <= '0;
      cmd_data   <= '0;
    end else begin
      cmd_enable <= frame_ok;
      if (frame_ok) begin
        cmd_write <= cmd_byte[7];
        cmd_addr  <= cmd_byte[6:0];
        cmd_data  <= {dh_byte, dl_byte};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Error counter: checksum mismatches and mid-frame gaps, sticking at 255.
  // Both sources cannot fire together because a byte suppresses the gap.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err_count <= '0;
    end else if ((frame_bad || gap_error) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Almost-full pass-through. Resets high so the receiver holds off until
  // the consumer's real status has been sampled.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      iafull <= 1'b1;
    end else begin
      iafull <= cmd_afull;
    end
  end

endmodule

// File: tb/tb_rs232_frame_decoder.sv
// Bench for rs232_frame_decoder: unit 0 uses the default gap timeout,
// unit 1 a short timeout of 16 cycles. A byte-level frame model predicts
// every command pulse, held command value and error count.
module tb_rs232_frame_decoder;
  import rs232_frame_decoder_pkg::*;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int TMO_LONG  = 1000000;
  localparam int TMO_SHORT = 16;

  logic        clock;
  logic        resetn;
  logic [7:0]  idata      [2];
  logic        ienable    [2];
  logic        iafull     [2];
  logic        cmd_write  [2];
  logic [6:0]  cmd_addr   [2];
  logic [15:0] cmd_data   [2];
  logic        cmd_enable [2];
  logic        cmd_afull  [2];
  logic [7:0]  err_count  [2];

  int checks = 0;
  int errors = 0;

  // Reference model state, per unit.
  int          m_tmo    [2] = '{TMO_LONG, TMO_SHORT};
  int          m_pos    [2];
  logic [7:0]  m_buf    [2][4];
  logic        m_wr     [2];
  logic [6:0]  m_addr   [2];
  logic [15:0] m_data   [2];
  int          m_err    [2];
  int          m_gap    [2];
  int          m_pulses [2];
  int          pulses   [2];

  rs232_frame_decoder dut_long (
    .clock(clock), .resetn(resetn),
    .idata(idata[0]), .ienable(ienable[0]), .iafull(iafull[0]),
    .cmd_write(cmd_write[0]), .cmd_addr(cmd_addr[0]), .cmd_data(cmd_data[0]),
    .cmd_enable(cmd_enable[0]), .cmd_afull(cmd_afull[0]), .err_count(err_count[0])
  );

  rs232_frame_decoder #(.TIMEOUT(TMO_SHORT), .SYNC_BYTE(SYNC)) dut_short (
    .clock(clock), .resetn(resetn),
    .idata(idata[1]), .ienable(ienable[1]), .iafull(iafull[1]),
    .cmd_write(cmd_write[1]), .cmd_addr(cmd_addr[1]), .cmd_data(cmd_data[1]),
    .cmd_enable(cmd_enable[1]), .cmd_afull(cmd_afull[1]), .err_count(err_count[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count every cycle in which a command strobe is seen.
  always @(negedge clock) begin
    if (cmd_enable[0] === 1'b1) pulses[0]++;
    if (cmd_enable[1] === 1'b1) pulses[1]++;
  end

  task automatic chk(input string tag, input int u, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s unit%0d observed %0h expected %0h", tag, u, got, exp);
    end
  endtask

  // ---- reference model --------------------------------------------------
  function automatic void model_reset(input int u);
    m_pos[u]  = 0;
    m_wr[u]   = 1'b0;
    m_addr[u] = '0;
    m_data[u] = '0;
    m_err[u]  = 0;
    m_gap[u]  = 0;
  endfunction

  function automatic void model_err(input int u);
    if (m_err[u] < 255) m_err[u]++;
  endfunction

  // A frame left open for TIMEOUT or more silent cycles is abandoned.
  function automatic void model_idle(input int u, input int n);
    m_gap[u] += n;
    if (m_pos[u] != 0 && m_gap[u] >= m_tmo[u]) begin
      m_pos[u] = 0;
      model_err(u);
    end
  endfunction

  // Returns 1 when this byte completes a frame with a good checksum.
  function automatic bit model_byte(input int u, input logic [7:0] b);
    bit p;
    p = 1'b0;
    m_gap[u] = 0;
    if (m_pos[u] == 0) begin
      if (b == SYNC) m_pos[u] = 1;
    end else if (m_pos[u] < FRAME_LEN - 1) begin
      m_buf[u][m_pos[u]] = b;
      m_pos[u]++;
    end else begin
      if (b == (m_buf[u][1] ^ m_buf[u][2] ^ m_buf[u][3])) begin
        m_wr[u]   = m_buf[u][1][7];
        m_addr[u] = m_buf[u][1][6:0];
        m_data[u] = {m_buf[u][2], m_buf[u][3]};
        m_pulses[u]++;
        p = 1'b1;
      end else begin
        model_err(u);
      end
      m_pos[u] = 0;
    end
    return p;
  endfunction

  // ---- stimulus helpers (entered and left on a falling edge) ------------
  task automatic chk_fields(input int u);
    chk("cmd_write", u, cmd_write[u], m_wr[u]);
    chk("cmd_addr",  u, cmd_addr[u],  m_addr[u]);
    chk("cmd_data",  u, cmd_data[u],  m_data[u]);
    chk("err_count", u, err_count[u], m_err[u]);
  endtask

  task automatic idle_cycles(input int u, input int n);
    if (n > 0) begin
      repeat (n) @(negedge clock);
      model_idle(u, n);
    end
  endtask

  task automatic send_byte(input int u, input logic [7:0] b, input int idle);
    bit p;
    idle_cycles(u, idle);
    idata[u]   = b;
    ienable[u] = 1'b1;
    @(negedge clock);
    ienable[u] = 1'b0;
    p = model_byte(u, b);
    chk("cmd_enable", u, cmd_enable[u], p);
    chk_fields(u);
  endtask

  task automatic send_frame(input int u, input logic [7:0] c, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] k, input int idle);
    send_byte(u, SYNC, idle);
    send_byte(u, c, idle);
    send_byte(u, h, idle);
    send_byte(u, l, idle);
    send_byte(u, k, idle);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    for (int u = 0; u < 2; u++) begin
      model_reset(u);
      chk("rst_cmd_enable", u, cmd_enable[u], 1'b0);
      chk("rst_iafull",     u, iafull[u],     1'b1);
      chk_fields(u);
    end
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic afull_step(input int u, input logic v);
    logic prev;
    prev = cmd_afull[u];
    cmd_afull[u] = v;
    #1;
    chk("iafull_hold", u, iafull[u], prev);
    @(negedge clock);
    chk("iafull_follow", u, iafull[u], v);
  endtask

  initial begin
    resetn = 1'b0;
    for (int u = 0; u < 2; u++) begin
      idata[u] = '0; ienable[u] = 1'b0; cmd_afull[u] = 1'b0;
      m_pulses[u] = 0; pulses[u] = 0;
      model_reset(u);
    end

    do_reset();

    // Leading garbage is dropped silently.
    send_byte(1, 8'h00, 0);
    send_byte(1, 8'h11, 0);
    send_byte(1, 8'hA4, 0);
    chk("garbage_err", 1, err_count[1], 8'd0);

    // Back-to-back write frame whose checksum equals the marker.
    send_frame(1, 8'h83, 8'h12, 8'h34, 8'hA5, 0);
    chk("b2b_write", 1, cmd_write[1], 1'b1);
    chk("b2b_addr",  1, cmd_addr[1],  7'h03);
    chk("b2b_data",  1, cmd_data[1],  16'h1234);
    chk("b2b_err",   1, err_count[1], 8'd0);
    idle_cycles(1, 1);
    chk("pulse_width", 1, cmd_enable[1], 1'b0);

    // Bad checksum: counted, command held; a following good frame decodes.
    send_frame(1, 8'h83, 8'h12, 8'h34, 8'h00, 0);
    chk("bad_err",  1, err_count[1], 8'd1);
    chk("bad_data", 1, cmd_data[1],  16'h1234);
    send_frame(1, 8'h05, 8'h00, 8'hFF, 8'hFA, 0);
    chk("after_bad_addr", 1, cmd_addr[1], 7'h05);

    // Slow read frame on the long-timeout unit, 1152 cycles per byte.
    send_frame(0, 8'h05, 8'h00, 8'hFF, 8'hFA, 1151);
    chk("slow_write", 0, cmd_write[0], 1'b0);
    chk("slow_addr",  0, cmd_addr[0],  7'h05);
    chk("slow_data",  0, cmd_data[0],  16'h00FF);

    // Gap timeout on the short unit, then recovery.
    do_reset();
    send_byte(1, SYNC, 0);
    send_byte(1, 8'h83, 0);
    idle_cycles(1, TMO_SHORT);
    chk("tmo_err", 1, err_count[1], 8'd1);
    send_frame(1, 8'h05, 8'h00, 8'hFF, 8'hFA, 0);
    chk("tmo_recover_data", 1, cmd_data[1], 16'h00FF);

    // A byte arriving on the expiry cycle is kept and the frame completes.
    send_byte(1, SYNC, 0);
    send_byte(1, 8'h83, TMO_SHORT - 1);
    send_byte(1, 8'h12, TMO_SHORT - 1);
    send_byte(1, 8'h34, TMO_SHORT - 1);
    send_byte(1, 8'hA5, TMO_SHORT - 1);
    chk("edge_err",  1, err_count[1], 8'd1);
    chk("edge_data", 1, cmd_data[1],  16'h1234);

    // Almost-full is registered once.
    afull_step(0, 1'b1); afull_step(0, 1'b0); afull_step(1, 1'b1);
    afull_step(1, 1'b1); afull_step(1, 1'b0);

    // Command strobe does not depend on consumer almost-full.
    cmd_afull[1] = 1'b1;
    send_frame(1, 8'h7F, 8'hBE, 8'hEF, 8'h7F ^ 8'hBE ^ 8'hEF, 0);
    cmd_afull[1] = 1'b0;

    // Reset in the middle of a frame discards it.
    send_byte(1, SYNC, 0);
    send_byte(1, 8'h83, 0);
    send_byte(1, 8'h12, 0);
    do_reset();
    send_byte(1, 8'h34, 0);
    send_byte(1, 8'hA5, 0);
    chk("midrst_err", 1, err_count[1], 8'd0);

    // Randomised traffic: noise, random gaps, occasional corrupt checksums.
    for (int f = 0; f < 60; f++) begin
      int u, gap, ngarb;
      logic [7:0] c, h, l, k;
      u = (f % 4 == 0) ? 0 : 1;
      c = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
      k = c ^ h ^ l;
      if ($urandom_range(0, 3) == 0) k = k ^ 8'($urandom_range(1, 255));
      ngarb = $urandom_range(0, 2);
      for (int g = 0; g < ngarb; g++) send_byte(u, 8'($urandom), 0);
      send_byte(u, SYNC, $urandom_range(0, 3));
      foreach (m_buf[0][i]) begin
        if (i == 0) continue;
        gap = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3);
        send_byte(u, (i == 1) ? c : (i == 2) ? h : l, gap);
      end
      send_byte(u, k, $urandom_range(0, 2));
    end

    // Error counter saturates.
    for (int f = 0; f < 300; f++) send_frame(1, 8'h01, 8'h02, 8'h03, 8'hFF, 0);
    chk("sat_err", 1, err_count[1], 8'd255);
    send_frame(1, 8'h01, 8'h02, 8'h03, 8'hFF, 0);
    chk("sat_hold", 1, err_count[1], 8'd255);

    idle_cycles(0, 2);
    idle_cycles(1, 0);
    chk("pulse_total", 0, pulses[0], m_pulses[0]);
    chk("pulse_total", 1, pulses[1], m_pulses[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs232_frame_decoder.md
RS232_FRAME_DECODER -- requirements
Module: rs232_frame_decoder

Interface
REQ-001 The block SHALL expose parameter TIMEOUT, integer, default 1000000, the mid-frame byte gap in clock cycles that aborts a frame.
REQ-002 The block SHALL expose parameter SYNC_BYTE, 8-bit, default 8'hA5, the frame start marker.
REQ-003 The block SHALL have port clock, input, 1, the single clock.
REQ-004 The block SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port idata, input, 8, the pushed byte from the serial receiver.
REQ-006 The block SHALL have port ienable, input, 1, a one-cycle strobe meaning idata is valid.
REQ-007 The block SHALL have port iafull, output, 1, almost-full back to the receiver.
REQ-008 The block SHALL have port cmd_write, output, 1, which is 1 for a write command and 0 for a read command.
REQ-009 The block SHALL have port cmd_addr, output, 7, the register address.
REQ-010 The block SHALL have port cmd_data, output, 16, the command payload.
REQ-011 The block SHALL have port cmd_enable, output, 1, a one-cycle command push strobe.
REQ-012 The block SHALL have port cmd_afull, input, 1, almost-full from the command consumer.
REQ-013 The block SHALL have port err_count, output, 8, a saturating frame error counter.

Function
REQ-014 The frame format SHALL be SYNC, CMD, DH, DL, CHK, where CMD[7] is write, CMD[6:0] is address, data is {DH,DL}, and CHK is CMD^DH^DL.
REQ-015 The FSM SHALL have states HUNT, CMD, DH, DL, CHK and SHALL advance only on cycles where ienable=1.
REQ-016 In HUNT, a byte equal to SYNC_BYTE SHALL move the FSM to CMD; any other byte SHALL be discarded silently with no error count.
REQ-017 CMD, DH and DL SHALL each latch their byte and advance to DH, DL and CHK respectively; a byte equal to SYNC_BYTE SHALL be treated as data in these states.
REQ-018 In CHK, a match SHALL assert cmd_enable for exactly one cycle, on the cycle after the CHK byte is sampled, with cmd_write, cmd_addr and cmd_data valid in that cycle; the FSM SHALL then return to HUNT.
REQ-019 In CHK, a mismatch SHALL produce no cmd_enable, SHALL increment err_count, and SHALL return the FSM to HUNT.
REQ-020 cmd_write, cmd_addr and cmd_data SHALL hold their values until the next valid frame, and SHALL NOT change on bad frames.
REQ-021 The gap timer SHALL reset on every ienable and count only outside HUNT.
REQ-022 When the gap timer reaches TIMEOUT-1 without a byte, the FSM SHALL go to HUNT and err_count SHALL increment.
REQ-023 If ienable and timer expiry coincide, the byte SHALL win: it is processed and there is no timeout.
REQ-024 err_count SHALL saturate at 255 and never wrap.
REQ-025 iafull SHALL equal cmd_afull registered once.
REQ-026 The block SHALL never refuse a byte.
REQ-027 cmd_enable SHALL be issued regardless of cmd_afull, per push semantics.
REQ-028 Back-to-back bytes on consecutive cycles SHALL be accepted, giving a minimum of 5 cycles per frame.

Reset
REQ-029 On resetn=0, the FSM SHALL enter HUNT and the timer SHALL clear.
REQ-030 On resetn=0, cmd_enable=0, cmd_write=0, cmd_addr=0, cmd_data=0, err_count=0, and iafull=1.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame with no error count and no cmd_enable.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the default SYNC_BYTE, and the frame length constant (5).
REQ-033 The gap timer SHALL be the sub-module frame_timer (inputs clear and run; output expire; parameter TIMEOUT), with width $clog2(TIMEOUT).
REQ-034 All other logic SHALL reside in rs232_frame_decoder.

Verification
REQ-035 Bytes A5 83 12 34 A5 back-to-back SHALL produce one cmd_enable pulse with cmd_write=1, cmd_addr=0x03, cmd_data=0x1234, and err_count=0; the CHK byte equals SYNC.
REQ-036 Bytes A5 05 00 FF FA spaced 1152 cycles apart SHALL produce cmd_write=0, cmd_addr=0x05, cmd_data=0x00FF, with cmd_enable one cycle after the FA strobe.
REQ-037 Bytes A5 83 12 34 00 SHALL produce no cmd_enable, err_count=1, and previous cmd outputs held; a following good frame SHALL then be decoded.
REQ-038 With TIMEOUT=16, A5 83 followed by 16 idle cycles SHALL set err_count=1 and return the FSM to HUNT; then A5 05 00 FF FA SHALL be decoded correctly.
REQ-039 Leading garbage 00 11 A4 SHALL leave err_count=0 and produce no cmd_enable.
REQ-040 Asserting resetn=0 after A5 83 12 SHALL restore all outputs to reset values.
REQ-041 Toggling cmd_afull SHALL make iafull follow it one cycle later.
REQ-042 300 bad frames SHALL leave err_count at 255.
